// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter, full/empty/almost flags and sticky error flags.
// Latency: write visible in count/flags 1 cycle after the edge. Registered read data is 1 cycle; in FWFT mode it is combinational.
// Backpressure: a write while full and a read while empty are dropped and set the sticky overflow or underflow flag.
//
// Ports: wclk/wrst_n (single clock, synchronous active-low reset), winc/wdata (write),
//        rinc/rdata (read), wfull/rempty/walmost_full/ralmost_empty (status), count (occupancy),
//        overflow/underflow (sticky errors, cleared only by reset).
// Build option: define SYNC_FIFO_FWFT_EN for first-word fall-through read data.
module sync_fifo #(
  parameter int DATASIZE      = 8,
  parameter int ADDRSIZE      = 4,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                wfull,
  output logic                rempty,
  output logic                walmost_full,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 2 ** ADDRSIZE;
  localparam logic [ADDRSIZE:0] DEPTH_C  = DEPTH[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] AFULL_C  = AFULL_THRESH[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] AEMPTY_C = AEMPTY_THRESH[ADDRSIZE:0];

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE:0]   rptr;
  logic                wr_acc;
  logic                rd_acc;

  // Status flags are pure decodes of the occupancy register.
  assign wfull         = (count == DEPTH_C);
  assign rempty        = (count == '0);
  assign walmost_full  = (count >= AFULL_C);
  assign ralmost_empty = (count <= AEMPTY_C);

  // Acceptance looks at the flags as they stood at the start of the cycle,
  // so on a full FIFO a simultaneous read does not make room for the write.
  assign wr_acc = winc && !wfull;
  assign rd_acc = rinc && !rempty;

  // Array has no reset; writes are suppressed while reset is asserted so a
  // reset cycle never leaves a stray word behind.
  always_ff @(posedge wclk) begin
    if (wrst_n && wr_acc) begin
      mem[wptr[ADDRSIZE-1:0]] <= wdata;
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_acc) begin
        rptr <= rptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (winc && wfull) begin
        overflow <= 1'b1;
      end
      if (rinc && rempty) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always on the output; rinc pops it.
  assign rdata = mem[rptr[ADDRSIZE-1:0]];
`else
  // Registered read: rdata updates only on an accepted read and holds otherwise.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      rdata <= '0;
    end else if (rd_acc) begin
      rdata <= mem[rptr[ADDRSIZE-1:0]];
    end
  end
`endif

endmodule
